// File: rtl/register.sv
// rtl/register.sv - dual-word parallel-to-serial frame transmitter with change detection
module register #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             data_out
);

  localparam int FRAME_LEN = 2 * WIDTH + 3;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     in1_q, in2_q;
  logic [WIDTH-1:0]     last1_q, last1_d;
  logic [WIDTH-1:0]     last2_q, last2_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pending;
  logic                 load;

  // The registered pair differs from the last pair that was put on the line.
  assign pending = ({in1_q, in2_q} != {last1_q, last2_q});

  // The line bit is always the bottom of the shift register, so it comes straight from a flop.
  assign data_out = shift_q[0];

  // Input stage: sample both words every edge; nothing else sees the raw inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      in1_q <= data_in1;
      in2_q <= data_in2;
    end
  end

  // Frame sequencing: decide when to load a new frame, when to shift, and when to go idle.
  always_comb begin
    state_d = state_q;
    last1_d = last1_q;
    last2_d = last2_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending) load = 1'b1;
      end
      SEND: begin
        if (cnt_q == LAST_BIT) begin
          // Stop bit ends here; a waiting pair starts back-to-back with no idle gap.
          if (pending) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            shift_d = '1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = {1'b1, shift_q[FRAME_LEN-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '1;
        cnt_d   = '0;
      end
    endcase

    // Frame image, LSB leaves first: start, word1, word2, even parity, stop.
    if (load) begin
      last1_d = in1_q;
      last2_d = in2_q;
      shift_d = {1'b1, ^{in1_q, in2_q}, in2_q, in1_q, 1'b0};
      cnt_d   = '0;
      state_d = SEND;
    end
  end

  // Frame state registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last1_q <= '0;
      last2_q <= '0;
      shift_q <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - randomized self-checking bench for register against a frame-queue model
module tb_register;

  localparam int W = 9;
  localparam int FRAME_LEN = 2 * W + 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in1;
  logic [W-1:0] data_in2;
  logic         data_out;

  int n_tests;
  int n_failed;

  // Reference model: registered inputs, last sent pair, queue of line bits still to appear.
  logic [W-1:0] m_in1, m_in2, m_last1, m_last2;
  bit           line_q[$];

  register #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in1 = '0; m_in2 = '0; m_last1 = '0; m_last2 = '0;
    line_q.delete();
  endfunction

  function automatic void push_frame(input logic [W-1:0] a, input logic [W-1:0] b);
    int ones;
    ones = $countones(a) + $countones(b);
    line_q.push_back(1'b0);
    for (int i = 0; i < W; i++) line_q.push_back(a[i]);
    for (int i = 0; i < W; i++) line_q.push_back(b[i]);
    line_q.push_back(bit'(ones % 2));
    line_q.push_back(1'b1);
  endfunction

  function automatic bit model_line();
    return (line_q.size() == 0) ? 1'b1 : line_q[0];
  endfunction

  // One clock edge: advance the model by the transmitter's rules, then compare the line.
  task automatic step(input string tag);
    bit pend;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pend = ({m_in1, m_in2} != {m_last1, m_last2});
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && pend) begin
        push_frame(m_in1, m_in2);
        m_last1 = m_in1;
        m_last2 = m_in2;
      end
      m_in1 = data_in1;
      m_in2 = data_in2;
    end
    #1;
    check(tag, {31'd0, data_out}, {31'd0, model_line()});
  endtask

  task automatic run_until_idle(input string tag);
    int guard;
    guard = 0;
    while (line_q.size() != 0 && guard < 200) begin
      step(tag);
      guard++;
    end
    check({tag, "_drained"}, {31'd0, (line_q.size() == 0)}, 32'd1);
  endtask

  logic [FRAME_LEN-1:0] cap;

  initial begin
    n_tests = 0;
    n_failed = 0;
    model_reset();
    rst = 1'b1;
    data_in1 = '0;
    data_in2 = '0;
    #1;
    check("reset_line", {31'd0, data_out}, 32'd1);
    step("reset_hold");
    step("reset_hold");
    @(posedge clk); #1;
    rst = 1'b0;

    // All-zero pair equals the reset snapshot: line must stay idle.
    for (int i = 0; i < 40; i++) step("idle_zero");

    // 0A5/000: start bit two edges after the change, then a hand-derived frame image.
    data_in1 = 9'h0A5;
    data_in2 = 9'h000;
    step("f0a5_in");
    step("f0a5_start");
    check("f0a5_latency", {31'd0, data_out}, 32'd0);
    cap = '0;
    cap[0] = data_out;
    for (int i = 1; i < FRAME_LEN; i++) begin
      step("f0a5_bits");
      cap[i] = data_out;
    end
    check("f0a5_frame", {11'd0, cap}, 32'h0010_014A);
    for (int i = 0; i < 5; i++) step("f0a5_idle");

    // 001/100 then only word2 changes to 101, flipping parity.
    data_in1 = 9'h001;
    data_in2 = 9'h100;
    run_until_idle("f001");
    step("f001_gap");
    data_in2 = 9'h101;
    run_until_idle("f101");
    for (int i = 0; i < 4; i++) step("f101_idle");

    // Changes mid-frame: only the value present at the next load is sent.
    data_in1 = 9'h0F0;
    step("mid_a");
    step("mid_b");
    for (int i = 0; i < 3; i++) step("mid_c");
    data_in1 = 9'h011;
    for (int i = 0; i < 4; i++) step("mid_d");
    data_in1 = 9'h022;
    run_until_idle("mid_e");
    check("mid_last1", {23'd0, m_last1}, 32'h022);

    // Reset in the middle of a frame forces the line high at once.
    data_in1 = 9'h155;
    data_in2 = 9'h0AA;
    step("rst_a");
    for (int i = 0; i < 11; i++) step("rst_b");
    rst = 1'b1;
    #1;
    check("rst_async", {31'd0, data_out}, 32'd1);
    step("rst_held");
    step("rst_held");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_until_idle("rst_fresh");
    for (int i = 0; i < 3; i++) step("rst_idle");

    // Random pairs held 6-8 cycles.
    for (int it = 0; it < 25; it++) begin
      int hold;
      data_in1 = W'($urandom);
      data_in2 = W'($urandom);
      hold = $urandom_range(8, 6);
      for (int c = 0; c < hold; c++) step("rand");
    end
    run_until_idle("rand_end");
    for (int i = 0; i < 5; i++) step("rand_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
